// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit: operation codes,
// FSM states and the default operand width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    // Bit 0 of the op code selects unsigned, bit 1 selects divide.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for the sign fix-up of products, quotients and remainders.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg_en,
    output logic [W-1:0] result
);

    assign result = neg_en ? (~value + W'(1)) : value;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO.
// One iteration runs in the accept cycle, the remaining WIDTH-1 in RUN.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_raw;
    logic             is_div;
    logic             sign_a;
    logic             sign_res;
    logic             div_zero;
    logic             done_r;

    // One multiply or divide iteration on the {hi, lo} accumulator pair.
    // Multiply: lo holds the remaining multiplier bits, d is the multiplicand.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    function automatic logic [2*WIDTH-1:0] md_step(
        input logic             div,
        input logic [WIDTH-1:0] hi_v,
        input logic [WIDTH-1:0] lo_v,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] addend;
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   rsh;
        logic [WIDTH:0]   diff;
        addend = lo_v[0] ? d : {WIDTH{1'b0}};
        sum    = {1'b0, hi_v} + {1'b0, addend};
        rsh    = {hi_v, lo_v[WIDTH-1]};
        diff   = rsh - {1'b0, d};
        if (!div) begin
            return {sum[WIDTH:1], sum[0], lo_v[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            return {diff[WIDTH-1:0], lo_v[WIDTH-2:0], 1'b1};
        end else begin
            return {rsh[WIDTH-1:0], lo_v[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Operand capture: magnitudes of the incoming sources
    logic             op_sgn, op_div;
    logic             neg_a_en, neg_b_en;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] init_lo, init_opnd;
    logic [2*WIDTH-1:0] step_init, step_run;
    logic             accept;

    assign op_sgn   = op_is_signed(op);
    assign op_div   = op_is_div(op);
    assign neg_a_en = op_sgn & src_a[WIDTH-1];
    assign neg_b_en = op_sgn & src_b[WIDTH-1];

    mdu_negate #(.W(WIDTH)) u_neg_a (
        .value  (src_a),
        .neg_en (neg_a_en),
        .result (mag_a)
    );

    mdu_negate #(.W(WIDTH)) u_neg_b (
        .value  (src_b),
        .neg_en (neg_b_en),
        .result (mag_b)
    );

    assign init_lo   = op_div ? mag_a : mag_b;
    assign init_opnd = op_div ? mag_b : mag_a;
    assign step_init = md_step(op_div, {WIDTH{1'b0}}, init_lo, init_opnd);
    assign step_run  = md_step(is_div, acc_hi, acc_lo, opnd);
    assign accept    = (state == ST_IDLE) && start && !flush;

    // Result fix-up: sign correction of product, quotient and remainder
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    mdu_negate #(.W(2*WIDTH)) u_neg_prod (
        .value  ({acc_hi, acc_lo}),
        .neg_en (sign_res),
        .result (prod_fix)
    );

    mdu_negate #(.W(WIDTH)) u_neg_quo (
        .value  (acc_lo),
        .neg_en (sign_res),
        .result (quo_fix)
    );

    mdu_negate #(.W(WIDTH)) u_neg_rem (
        .value  (acc_hi),
        .neg_en (sign_a),
        .result (rem_fix)
    );

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (div_zero) begin
            res_hi = a_raw;
            res_lo = {WIDTH{1'b1}};
        end else if (is_div) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start && !flush) state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush)                 state_nxt = ST_IDLE;
                else if (cnt == LAST_CNT)  state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath, counter and architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_res <= 1'b0;
            div_zero <= 1'b0;
            done_r   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        acc_hi   <= step_init[2*WIDTH-1:WIDTH];
                        acc_lo   <= step_init[WIDTH-1:0];
                        opnd     <= init_opnd;
                        a_raw    <= src_a;
                        is_div   <= op_div;
                        sign_a   <= neg_a_en;
                        sign_res <= neg_a_en ^ neg_b_en;
                        div_zero <= op_div && (src_b == '0);
                        cnt      <= CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        acc_hi <= step_run[2*WIDTH-1:WIDTH];
                        acc_lo <= step_run[WIDTH-1:0];
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    cnt <= '0;
                    if (!flush) begin
                        hi     <= res_hi;
                        lo     <= res_lo;
                        done_r <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_FIX);
    assign done = done_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO and completion cycle are
// queued at each accepted start and compared whenever done pulses.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;
    exp_t sb[$];

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("latency", cyc, e.due);
                chk("busy_in_done", busy, 1'b0);
            end
        end
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq, sr;
        case (o)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            2'b01: return {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit push);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (push) sb.push_back('{exp[63:32], exp[31:0], cyc + 33});
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        bit got;
        got = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                got = 1;
                break;
            end
            step();
        end
        chk("done_seen", got, 1'b1);
        step();
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int bc;
        launch(o, a, b, exp, 1'b1);
        wait_done(bc);
    endtask

    initial begin
        int          bc;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        logic [31:0] hi_before;

        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst = 1'b0;
        step();

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_done(bc);
        chk("busy_cycles", bc, 32);

        run_op(2'b00, 32'hFFFF_FFF9, 32'd3,        64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd100,       32'd7,        64'h0000_0002_0000_000E);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF7, 32'd0,        64'hFFFF_FFF7_FFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h0000_0000_0000_001E);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        for (int i = 0; i < 8; i++) begin
            r_op = 2'(i);
            r_a  = $urandom;
            r_b  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 5) r_a = 32'($urandom_range(0, 50));
            run_op(r_op, r_a, r_b, model(r_op, r_a, r_b));
        end

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h1234);

        // Flush ten cycles into a run
        launch(2'b01, 32'hFFFF_FFFF, 32'h2, 64'h0, 1'b0);
        repeat (9) step();
        chk("busy_before_flush", busy, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h1234);
        repeat (40) step();
        chk("flush_hi_late", hi, 32'h1234);

        // Flush and start together in IDLE
        op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 1'b0);

        // MTHI and a second start while busy are both dropped
        launch(2'b01, 32'd3, 32'd4, 64'd12, 1'b1);
        hi_before = hi;
        repeat (3) step();
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        op = 2'b11; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
        step();
        hi_we = 1'b0; start = 1'b0;
        chk("hi_we_busy", hi, {32'h0, hi_before});
        wait_done(bc);
        repeat (36) step();

        // MTHI in the accept cycle applies, completion overwrites it
        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        launch(2'b01, 32'd2, 32'd3, 64'd6, 1'b1);
        hi_we = 1'b0;
        chk("hi_we_at_start", hi, 32'hAAAA_5555);
        wait_done(bc);
        chk("hi_after_overwrite", hi, 32'h0);

        // Synchronous reset in RUN
        run_op(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        launch(2'b01, 32'd5, 32'd5, 64'd25, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        repeat (40) step();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
